// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode stage of the 16-bit ISA pipeline.
// Holds the 8-entry register file with optional write-first bypass,
// destination-register selection, immediate extension to DATA_W,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipe #(
  parameter int DATA_W      = 16,
  parameter int BYPASS_EN   = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int HAZARD_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [1:0]        id_rd_mode,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [2:0]        ex_wsel,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_imm5s,
  output logic [DATA_W-1:0] ex_imm5z,
  output logic [DATA_W-1:0] ex_imm8s,
  output logic [DATA_W-1:0] ex_imm8z,
  output logic [DATA_W-1:0] ex_d11s,
  output logic [15:0]       hazard_cnt
);

  // Immediate extension helpers
  function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{(DATA_W-5){v[4]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] zext5(input logic [4:0] v);
    return {{(DATA_W-5){1'b0}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] zext8(input logic [7:0] v);
    return {{(DATA_W-8){1'b0}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] v);
    return {{(DATA_W-11){v[10]}}, v};
  endfunction

  // Saturating increment for the stall-cycle counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [DATA_W-1:0]        rf [8];

  logic [2:0]               rs_sel_p0;
  logic [2:0]               rt_sel_p0;
  logic [DATA_W-1:0]        rs_data_p0;
  logic [DATA_W-1:0]        rt_data_p0;
  logic [2:0]               wsel_p0;
  logic signed [DATA_W-1:0] imm5s_p0;
  logic signed [DATA_W-1:0] imm5z_p0;
  logic signed [DATA_W-1:0] imm8s_p0;
  logic signed [DATA_W-1:0] imm8z_p0;
  logic signed [DATA_W-1:0] d11s_p0;
  logic                     rs_hit_p0;
  logic                     rt_hit_p0;
  logic                     hazard_stall;

  logic                     vld_p1;
  logic [15:0]              instr_p1;
  logic [DATA_W-1:0]        rs_data_p1;
  logic [DATA_W-1:0]        rt_data_p1;
  logic [2:0]               wsel_p1;
  logic                     reg_write_p1;
  logic                     mem_read_p1;
  logic signed [DATA_W-1:0] imm5s_p1;
  logic signed [DATA_W-1:0] imm5z_p1;
  logic signed [DATA_W-1:0] imm8s_p1;
  logic signed [DATA_W-1:0] imm8z_p1;
  logic signed [DATA_W-1:0] d11s_p1;
  logic [15:0]              hazard_cnt_q;

  assign rs_sel_p0 = id_instr[10:8];
  assign rt_sel_p0 = id_instr[7:5];

  // Register file write port; R0 optionally hard-wired to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_en && !((ZERO_REG_EN != 0) && (wb_sel == 3'd0))) begin
      rf[wb_sel] <= wb_data;
    end
  end

  // Read ports: array read, optional write-first bypass, then R0 forcing
  always_comb begin
    rs_data_p0 = rf[rs_sel_p0];
    rt_data_p0 = rf[rt_sel_p0];
    if ((BYPASS_EN != 0) && wb_en && (wb_sel == rs_sel_p0)) rs_data_p0 = wb_data;
    if ((BYPASS_EN != 0) && wb_en && (wb_sel == rt_sel_p0)) rt_data_p0 = wb_data;
    if ((ZERO_REG_EN != 0) && (rs_sel_p0 == 3'd0)) rs_data_p0 = '0;
    if ((ZERO_REG_EN != 0) && (rt_sel_p0 == 3'd0)) rt_data_p0 = '0;
  end

  // Destination register selection from the control unit's mode
  always_comb begin
    wsel_p0 = 3'd7;
    case (id_rd_mode)
      2'b00:   wsel_p0 = id_instr[4:2];
      2'b01:   wsel_p0 = id_instr[7:5];
      2'b10:   wsel_p0 = id_instr[10:8];
      default: wsel_p0 = 3'd7;
    endcase
  end

  // Immediate extension of the ID instruction fields
  always_comb begin
    imm5s_p0 = sext5(id_instr[4:0]);
    imm5z_p0 = zext5(id_instr[4:0]);
    imm8s_p0 = sext8(id_instr[7:0]);
    imm8z_p0 = zext8(id_instr[7:0]);
    d11s_p0  = sext11(id_instr[10:0]);
  end

  // Load-use detection against the load currently in EX; a load into a
  // hard-wired R0 produces nothing to wait for
  always_comb begin
    rs_hit_p0    = id_uses_rs && (wsel_p1 == rs_sel_p0);
    rt_hit_p0    = id_uses_rt && (wsel_p1 == rt_sel_p0);
    hazard_stall = (HAZARD_EN != 0) && id_valid && vld_p1 && mem_read_p1 &&
                   reg_write_p1 && (rs_hit_p0 || rt_hit_p0) &&
                   !((ZERO_REG_EN != 0) && (wsel_p1 == 3'd0));
  end

  // flush wins over any stall request so the squashed slot never freezes fetch
  assign stall_out = !rst && !flush && (stall_in || hazard_stall);

  // ---- ID -> EX boundary ----
  // ID/EX register: reset, flush, downstream hold, bubble, then normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      instr_p1     <= '0;
      rs_data_p1   <= '0;
      rt_data_p1   <= '0;
      wsel_p1      <= '0;
      imm5s_p1     <= '0;
      imm5z_p1     <= '0;
      imm8s_p1     <= '0;
      imm8z_p1     <= '0;
      d11s_p1      <= '0;
    end else if (flush || (!stall_in && hazard_stall)) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
    end else if (!stall_in) begin
      vld_p1       <= id_valid;
      reg_write_p1 <= id_reg_write && id_valid;
      mem_read_p1  <= id_mem_read && id_valid;
      instr_p1     <= id_instr;
      rs_data_p1   <= rs_data_p0;
      rt_data_p1   <= rt_data_p0;
      wsel_p1      <= wsel_p0;
      imm5s_p1     <= imm5s_p0;
      imm5z_p1     <= imm5z_p0;
      imm8s_p1     <= imm8s_p0;
      imm8z_p1     <= imm8z_p0;
      d11s_p1      <= d11s_p0;
    end
  end

  // Count cycles actually lost to load-use bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt_q <= '0;
    end else if (hazard_stall && !stall_in && !flush) begin
      hazard_cnt_q <= sat_inc16(hazard_cnt_q);
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_instr     = instr_p1;
  assign ex_rs_data   = rs_data_p1;
  assign ex_rt_data   = rt_data_p1;
  assign ex_wsel      = wsel_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_mem_read  = mem_read_p1;
  assign ex_imm5s     = imm5s_p1;
  assign ex_imm5z     = imm5z_p1;
  assign ex_imm8s     = imm8s_p1;
  assign ex_imm8z     = imm8z_p1;
  assign ex_d11s      = d11s_p1;
  assign hazard_cnt   = hazard_cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: two configurations driven by shared inputs,
// each compared every cycle against a behavioural model of the decode stage.
//   A: DATA_W=32, bypass on,  R0 ordinary
//   B: DATA_W=16, bypass off, R0 hard-wired zero
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_reg_write, id_mem_read, id_uses_rs, id_uses_rt;
  logic        flush, stall_in, wb_en;
  logic [15:0] id_instr;
  logic [1:0]  id_rd_mode;
  logic [2:0]  wb_sel;
  logic [31:0] wb_data;

  logic        a_st, a_v, a_rw, a_mr;
  logic [15:0] a_instr, a_cnt;
  logic [2:0]  a_wsel;
  logic [31:0] a_rs, a_rt, a_i5s, a_i5z, a_i8s, a_i8z, a_d11s;

  logic        b_st, b_v, b_rw, b_mr;
  logic [15:0] b_instr, b_cnt;
  logic [2:0]  b_wsel;
  logic [15:0] b_rs, b_rt, b_i5s, b_i5z, b_i8s, b_i8z, b_d11s;

  decode_stage_pipe #(.DATA_W(32), .BYPASS_EN(1), .ZERO_REG_EN(0), .HAZARD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rd_mode(id_rd_mode),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .flush(flush), .stall_in(stall_in),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .stall_out(a_st), .ex_valid(a_v), .ex_instr(a_instr), .ex_rs_data(a_rs),
    .ex_rt_data(a_rt), .ex_wsel(a_wsel), .ex_reg_write(a_rw), .ex_mem_read(a_mr),
    .ex_imm5s(a_i5s), .ex_imm5z(a_i5z), .ex_imm8s(a_i8s), .ex_imm8z(a_i8z),
    .ex_d11s(a_d11s), .hazard_cnt(a_cnt)
  );

  decode_stage_pipe #(.DATA_W(16), .BYPASS_EN(0), .ZERO_REG_EN(1), .HAZARD_EN(1)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rd_mode(id_rd_mode),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .flush(flush), .stall_in(stall_in),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data[15:0]),
    .stall_out(b_st), .ex_valid(b_v), .ex_instr(b_instr), .ex_rs_data(b_rs),
    .ex_rt_data(b_rt), .ex_wsel(b_wsel), .ex_reg_write(b_rw), .ex_mem_read(b_mr),
    .ex_imm5s(b_i5s), .ex_imm5z(b_i5z), .ex_imm8s(b_i8s), .ex_imm8z(b_i8z),
    .ex_d11s(b_d11s), .hazard_cnt(b_cnt)
  );

  // Model of what EX should hold; known=0 where the contents are don't-care
  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [63:0] rs;
    logic [63:0] rt;
    logic [2:0]  wsel;
    logic        rw;
    logic        mr;
    logic        known;
  } ex_t;

  ex_t         mex [2];
  logic [63:0] mrf [2][8];
  int unsigned mcnt [2];
  logic        last_st [2];
  logic        exp_st [2];
  int          checks = 0;
  int          errors = 0;

  function automatic int width(input int k);
    return (k == 0) ? 32 : 16;
  endfunction
  function automatic bit cfg_bypass(input int k);
    return k == 0;
  endfunction
  function automatic bit cfg_zero(input int k);
    return k == 1;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Two's-complement value of the low 'bits' of v, expressed in w bits
  function automatic logic [63:0] sx(input logic [15:0] v, input int bits, input int w);
    longint val;
    val = longint'({48'd0, v}) & ((longint'(1) << bits) - 1);
    if (val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
    return 64'(val) & wmask(w);
  endfunction

  function automatic logic [63:0] zx(input logic [15:0] v, input int bits);
    return {48'd0, v} & ((64'd1 << bits) - 64'd1);
  endfunction

  function automatic logic [63:0] m_read(input int k, input logic [2:0] sel);
    if (cfg_zero(k) && sel == 3'd0) return 64'd0;
    if (cfg_bypass(k) && wb_en && wb_sel == sel) return {32'd0, wb_data} & wmask(width(k));
    return mrf[k][sel];
  endfunction

  function automatic logic [2:0] m_dest();
    case (id_rd_mode)
      2'd0:    return id_instr[4:2];
      2'd1:    return id_instr[7:5];
      2'd2:    return id_instr[10:8];
      default: return 3'd7;
    endcase
  endfunction

  // A load in EX whose destination the ID instruction reads
  function automatic logic m_haz(input int k);
    logic dep;
    dep = (id_uses_rs && mex[k].wsel == id_instr[10:8]) ||
          (id_uses_rt && mex[k].wsel == id_instr[7:5]);
    if (cfg_zero(k) && mex[k].wsel == 3'd0) dep = 1'b0;
    return id_valid && mex[k].v && mex[k].mr && mex[k].rw && dep;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_update(input int k, input logic haz);
    if (rst) begin
      mex[k] = '{default: '0};
      mex[k].known = 1'b1;
      for (int r = 0; r < 8; r++) mrf[k][r] = 64'd0;
      mcnt[k] = 0;
    end else begin
      if (flush || (!stall_in && haz)) begin
        mex[k].v = 1'b0; mex[k].rw = 1'b0; mex[k].mr = 1'b0; mex[k].known = 1'b0;
      end else if (!stall_in) begin
        mex[k].v     = id_valid;
        mex[k].instr = id_instr;
        mex[k].rs    = m_read(k, id_instr[10:8]);
        mex[k].rt    = m_read(k, id_instr[7:5]);
        mex[k].wsel  = m_dest();
        mex[k].rw    = id_reg_write && id_valid;
        mex[k].mr    = id_mem_read && id_valid;
        mex[k].known = 1'b1;
      end
      if (haz && !stall_in && !flush && mcnt[k] < 32'd65535) mcnt[k]++;
      if (wb_en && !(cfg_zero(k) && wb_sel == 3'd0))
        mrf[k][wb_sel] = {32'd0, wb_data} & wmask(width(k));
    end
  endtask

  task automatic chk_ex(input int k, input logic v, input logic rw, input logic mr,
                        input logic [15:0] ins, input logic [2:0] ws,
                        input logic [63:0] rs, input logic [63:0] rt,
                        input logic [63:0] i5s, input logic [63:0] i5z,
                        input logic [63:0] i8s, input logic [63:0] i8z,
                        input logic [63:0] d11s, input logic [15:0] cnt);
    string p;
    int    w;
    p = (k == 0) ? "A." : "B.";
    w = width(k);
    chk({p, "ex_valid"}, 64'(v), 64'(mex[k].v));
    chk({p, "ex_reg_write"}, 64'(rw), 64'(mex[k].rw));
    chk({p, "ex_mem_read"}, 64'(mr), 64'(mex[k].mr));
    chk({p, "hazard_cnt"}, 64'(cnt), 64'(mcnt[k]));
    if (mex[k].known) begin
      chk({p, "ex_instr"}, 64'(ins), 64'(mex[k].instr));
      chk({p, "ex_wsel"}, 64'(ws), 64'(mex[k].wsel));
      chk({p, "ex_rs_data"}, rs, mex[k].rs);
      chk({p, "ex_rt_data"}, rt, mex[k].rt);
      chk({p, "ex_imm5s"}, i5s, sx(mex[k].instr, 5, w));
      chk({p, "ex_imm5z"}, i5z, zx(mex[k].instr, 5));
      chk({p, "ex_imm8s"}, i8s, sx(mex[k].instr, 8, w));
      chk({p, "ex_imm8z"}, i8z, zx(mex[k].instr, 8));
      chk({p, "ex_d11s"}, d11s, sx(mex[k].instr, 11, w));
    end
  endtask

  // One clock: check stall_out mid-cycle, advance the model, check EX after the edge
  task automatic step();
    logic haz [2];
    #2;
    for (int k = 0; k < 2; k++) begin
      haz[k]     = m_haz(k);
      exp_st[k]  = !rst && !flush && (stall_in || haz[k]);
      last_st[k] = (k == 0) ? a_st : b_st;
      chk((k == 0) ? "A.stall_out" : "B.stall_out", 64'(last_st[k]), 64'(exp_st[k]));
      m_update(k, haz[k]);
    end
    @(posedge clk);
    #1;
    chk_ex(0, a_v, a_rw, a_mr, a_instr, a_wsel, 64'(a_rs), 64'(a_rt), 64'(a_i5s),
           64'(a_i5z), 64'(a_i8s), 64'(a_i8z), 64'(a_d11s), a_cnt);
    chk_ex(1, b_v, b_rw, b_mr, b_instr, b_wsel, 64'(b_rs), 64'(b_rt), 64'(b_i5s),
           64'(b_i5z), 64'(b_i8s), 64'(b_i8z), 64'(b_d11s), b_cnt);
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_instr = 16'd0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_rd_mode = 2'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    flush = 1'b0; stall_in = 1'b0; wb_en = 1'b0; wb_sel = 3'd0; wb_data = 32'd0;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [1:0] mode, input logic rw,
                       input logic mr, input logic urs, input logic urt);
    id_valid = 1'b1; id_instr = ins; id_rd_mode = mode; id_reg_write = rw;
    id_mem_read = mr; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mex[k] = '{default: '0};
      mcnt[k] = 0;
      for (int r = 0; r < 8; r++) mrf[k][r] = 64'd0;
    end
    idle();

    // Reset, with a downstream stall requested to show reset masks it
    rst = 1'b1; stall_in = 1'b1; wb_en = 1'b1; wb_sel = 3'd4; wb_data = 32'hDEAD;
    issue(16'h0440, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    chk("reset A.stall_out", 64'(last_st[0]), 64'd0);
    chk("reset A.ex_valid", 64'(a_v), 64'd0);
    chk("reset A.hazard_cnt", 64'(a_cnt), 64'd0);
    idle();

    // Freshly reset registers read as zero
    issue(16'h05C0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("reset A.R5", 64'(a_rs), 64'd0);
    chk("reset A.R6", 64'(a_rt), 64'd0);

    // Write-back to R3 in the same cycle R3 is read
    wb_en = 1'b1; wb_sel = 3'd3; wb_data = 32'h1234;
    issue(16'h0300, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bypass A.rs", 64'(a_rs), 64'h1234);
    chk("nobypass B.rs", 64'(b_rs), 64'h0);
    wb_en = 1'b0;
    step();
    chk("reissue B.rs", 64'(b_rs), 64'h1234);

    // Load to R2 followed by a reader of R2 in [7:5]
    issue(16'h0200, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    issue(16'h0040, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("loaduse A.stall_out", 64'(last_st[0]), 64'd1);
    chk("loaduse B.stall_out", 64'(last_st[1]), 64'd1);
    chk("loaduse A.bubble", 64'(a_v), 64'd0);
    step();
    chk("loaduse A.no_stall", 64'(last_st[0]), 64'd0);
    chk("loaduse A.issued", 64'(a_v), 64'd1);
    chk("loaduse A.instr", 64'(a_instr), 64'h0040);
    chk("loaduse A.hazard_cnt", 64'(a_cnt), 64'd1);
    chk("loaduse B.hazard_cnt", 64'(b_cnt), 64'd1);

    // Flush beats both a hazard and a downstream stall
    issue(16'h0200, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    issue(16'h0040, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    flush = 1'b1; stall_in = 1'b1;
    step();
    chk("flush A.stall_out", 64'(last_st[0]), 64'd0);
    chk("flush A.ex_valid", 64'(a_v), 64'd0);
    chk("flush A.hazard_cnt", 64'(a_cnt), 64'd1);
    idle();

    // R0 writes and R0 load-use
    wb_en = 1'b1; wb_sel = 3'd0; wb_data = 32'hBEEF;
    step();
    wb_en = 1'b0;
    issue(16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("r0 A.rs", 64'(a_rs), 64'hBEEF);
    chk("r0 B.rs", 64'(b_rs), 64'h0);
    issue(16'h0000, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    issue(16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("r0use A.stall_out", 64'(last_st[0]), 64'd1);
    chk("r0use B.stall_out", 64'(last_st[1]), 64'd0);
    chk("r0use B.ex_valid", 64'(b_v), 64'd1);

    // Destination R7 and immediate extension
    issue(16'h3000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("rd_mode3 A.wsel", 64'(a_wsel), 64'd7);
    issue(16'h0080, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("imm8s B", 64'(b_i8s), 64'hFF80);
    chk("imm8z B", 64'(b_i8z), 64'h0080);
    chk("imm8s A", 64'(a_i8s), 64'hFFFF_FF80);

    // Randomised traffic; a stalled instruction is held in ID as the front end would
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom % 64) == 0;
      flush    = ($urandom % 10) == 0;
      stall_in = ($urandom % 8) == 0;
      wb_en    = $urandom % 2;
      wb_sel   = 3'($urandom);
      wb_data  = $urandom;
      if (!exp_st[0]) begin
        issue(16'($urandom), 2'($urandom), 1'($urandom), ($urandom % 3) == 0,
              1'($urandom), 1'($urandom));
        id_valid = ($urandom % 5) != 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised decode stage for the 16-bit ISA pipeline, generalised in data width.
- Contains a bypassed register file (8 entries), destination-register selection, and immediate extension to DATA_W.
- Contains a load-use hazard detector and the registered ID/EX pipeline boundary with flush/stall handling.
- Sits between the IF/ID register and execute; the external control unit drives the per-instruction control inputs.

Parameters:
- DATA_W, 16, register/datapath width; legal range 16..64.
- BYPASS_EN, 1: 1 = a same-cycle WB write is visible on the read ports (write-first); 0 = the old value is read.
- ZERO_REG_EN, 0: 1 = R0 reads as 0 and writes to R0 are discarded.
- HAZARD_EN, 1: 1 = load-use detection enabled; 0 = hazard_stall is tied 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  16  instruction
- id_reg_write  in  1  instruction writes a register (from control unit)
- id_mem_read  in  1  instruction is a load
- id_rd_mode  in  2  dest select: 00 = [4:2], 01 = [7:5], 10 = [10:8], 11 = R7
- id_uses_rs  in  1  instruction reads [10:8]
- id_uses_rt  in  1  instruction reads [7:5]
- flush  in  1  squash the instruction in ID (taken branch/jump)
- stall_in  in  1  downstream stall; hold ID/EX
- wb_en  in  1  write-back enable
- wb_sel  in  3  write-back register
- wb_data  in  DATA_W  write-back data
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX valid
- ex_instr  out  16  registered instruction
- ex_rs_data  out  DATA_W  registered read of [10:8]
- ex_rt_data  out  DATA_W  registered read of [7:5]
- ex_wsel  out  3  registered destination register
- ex_reg_write  out  1  registered, qualified by ex_valid
- ex_mem_read  out  1  registered, qualified by ex_valid
- ex_imm5s  out  DATA_W  sign-extended [4:0]
- ex_imm5z  out  DATA_W  zero-extended [4:0]
- ex_imm8s  out  DATA_W  sign-extended [7:0]
- ex_imm8z  out  DATA_W  zero-extended [7:0]
- ex_d11s  out  DATA_W  sign-extended [10:0]
- hazard_cnt  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (sync):
  - All 8 registers clear to 0.
  - ex_valid, ex_reg_write, ex_mem_read clear to 0.
  - All other ex_* clear to 0.
  - hazard_cnt clears to 0.
  - stall_out is 0 while rst is high.
  - Reset mid-operation discards any in-flight instruction.
- Register file:
  - Write on posedge when wb_en=1 and rst=0.
  - When ZERO_REG_EN=1, a write with wb_sel=0 is ignored and R0 always reads as 0.
  - Read is combinational. With BYPASS_EN=1, a read of wb_sel while wb_en=1 returns wb_data; the ZERO_REG_EN rule still applies to R0.
- Dest select: combinational per id_rd_mode, then registered into ex_wsel.
- Load-use hazard (combinational), hazard_stall = HAZARD_EN & id_valid & ex_valid & ex_mem_read & ex_reg_write & ((id_uses_rs & ex_wsel==id_instr[10:8]) | (id_uses_rt & ex_wsel==id_instr[7:5])).
  - When ZERO_REG_EN=1, a match on register 0 does not count.
- stall_out = ~rst & ~flush & (stall_in | hazard_stall).
- ID/EX update priority each posedge:
  1. rst.
  2. flush: ex_valid←0. Other ex_* are don't-care but ex_reg_write/ex_mem_read←0.
  3. stall_in: all ex_* hold.
  4. hazard_stall: insert a bubble (ex_valid, ex_reg_write, ex_mem_read ← 0); the ID instruction is re-presented next cycle.
  5. Otherwise load from ID. ex_valid←id_valid; ex_reg_write/ex_mem_read are ANDed with id_valid.
- Latency: 1 cycle ID→EX. A load-use dependency costs exactly 1 bubble cycle.
- hazard_cnt increments on each cycle where hazard_stall=1 and stall_in=0 and flush=0. It saturates at 16'hFFFF.
- Immediates are registered alongside the instruction and extended to DATA_W.

Test Plan:
- Reset with DATA_W=32 → ex_valid=0, all registers read 0, hazard_cnt=0, stall_out=0.
- wb_en=1, wb_sel=3, wb_data=0x1234 while id_instr reads R3 as rs:
  - BYPASS_EN=1 → ex_rs_data=0x1234 after 1 clk.
  - BYPASS_EN=0 → ex_rs_data=0 in that cycle and 0x1234 on the next issue.
- Load to R2 in EX, followed by an ID instruction with id_uses_rt=1 and [7:5]=2:
  - stall_out=1 for 1 cycle.
  - The next ex_valid=0, then the dependent instruction issues.
  - hazard_cnt=1.
- flush asserted in the same cycle as a load-use hazard and stall_in → stall_out=0; ex_valid=0 next cycle; hazard_cnt unchanged.
- ZERO_REG_EN=1, write 0xBEEF to R0 → R0 still reads 0. A load to R0 followed by a use of R0 causes no stall.
- id_rd_mode=11 with id_instr=0x3000 → ex_wsel=7. id_instr[7:0]=0x80 with DATA_W=16 → ex_imm8s=0xFF80 and ex_imm8z=0x0080.
